// File: rtl/handshake_responder_pkg.sv
// Shared constants for the handshake responder and the other synchronizing blocks.
package handshake_responder_pkg;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] HOLD = 2'b01;
  localparam logic [1:0] ACK  = 2'b10;

  localparam int DEFAULT_STAGES = 2;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_HOLD = HOLD,
    ST_ACK  = ACK
  } state_e;

endpackage

// File: rtl/handshake_responder_bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous bit, with a synchronous
// reset whose active level is a parameter.
module bit_synchronizer
  import handshake_responder_pkg::*;
#(
  parameter int STAGES             = DEFAULT_STAGES,
  parameter bit RESET_ACTIVE_LEVEL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i == RESET_ACTIVE_LEVEL) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/handshake_responder.sv
// Receive-side four-phase req/ack endpoint presenting words on a valid/ready port.
// Optional feature macro: HANDSHAKE_RESPONDER_EARLY_ACK_EN (ack at capture, one word of buffering).
module handshake_responder
  import handshake_responder_pkg::*;
#(
  parameter int WORD_LENGTH = 8,
  parameter int STAGES      = DEFAULT_STAGES,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   Req_in,
  input  logic [WORD_LENGTH-1:0] Data_in,
  output logic                   Ack_out,
  output logic [WORD_LENGTH-1:0] Rx_data,
  output logic                   Rx_valid,
  input  logic                   Rx_ready,
  output logic                   Busy,
  output logic [COUNT_WIDTH-1:0] Xfer_count
);

  if (WORD_LENGTH < 1) begin : g_bad_word_length
    $error("handshake_responder: WORD_LENGTH must be > 0");
  end
  if (STAGES < 2) begin : g_bad_stages
    $error("handshake_responder: STAGES must be >= 2");
  end
  if (COUNT_WIDTH < 1) begin : g_bad_count_width
    $error("handshake_responder: COUNT_WIDTH must be >= 1");
  end

  logic                   req_sync;
  state_e                 state_q, state_d;
  logic                   ack_q, ack_d;
  logic                   valid_q, valid_d;
  logic [WORD_LENGTH-1:0] data_q, data_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  bit_synchronizer #(
    .STAGES             (STAGES),
    .RESET_ACTIVE_LEVEL (1'b0)
  ) u_req_sync (
    .clk_i (Clock),
    .rst_i (Reset),
    .d_i   (Req_in),
    .q_o   (req_sync)
  );

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    valid_d = valid_q;
    data_d  = data_q;
    count_d = count_q;
`ifdef HANDSHAKE_RESPONDER_EARLY_ACK_EN
    // Consume is independent of the FSM; a same-edge capture overrides it below.
    if (valid_q && Rx_ready) begin
      valid_d = 1'b0;
    end
    case (state_q)
      ST_IDLE: begin
        if (req_sync && (!valid_q || Rx_ready)) begin
          data_d  = Data_in;
          valid_d = 1'b1;
          count_d = count_q + 1'b1;
          ack_d   = 1'b1;
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        if (!req_sync) begin
          ack_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ack_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
`else
    case (state_q)
      ST_IDLE: begin
        if (req_sync) begin
          data_d  = Data_in;
          valid_d = 1'b1;
          count_d = count_q + 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (Rx_ready) begin
          valid_d = 1'b0;
          ack_d   = 1'b1;
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        if (!req_sync) begin
          ack_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ack_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
`endif
  end

  assign Ack_out    = ack_q;
  assign Rx_valid   = valid_q;
  assign Rx_data    = data_q;
  assign Xfer_count = count_q;
  assign Busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_handshake_responder.sv
// Bench for handshake_responder: a transaction-level remote transmitter and sink,
// with a second instance using a 2-bit counter to exercise wrap-around.
module tb_handshake_responder;

  localparam int STG = 2;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Req_in;
  logic [7:0]  Data_in;
  logic        Rx_ready;

  logic        Ack_out, Rx_valid, Busy;
  logic [7:0]  Rx_data;
  logic [15:0] Xfer_count;

  logic        ack2, valid2, busy2;
  logic [7:0]  data2;
  logic [1:0]  cnt2;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_count;

  always #5 Clock = ~Clock;

  handshake_responder #(.WORD_LENGTH(8), .STAGES(STG), .COUNT_WIDTH(16)) dut (
    .Clock(Clock), .Reset(Reset), .Req_in(Req_in), .Data_in(Data_in),
    .Ack_out(Ack_out), .Rx_data(Rx_data), .Rx_valid(Rx_valid), .Rx_ready(Rx_ready),
    .Busy(Busy), .Xfer_count(Xfer_count)
  );

  handshake_responder #(.WORD_LENGTH(8), .STAGES(STG), .COUNT_WIDTH(2)) dut_w2 (
    .Clock(Clock), .Reset(Reset), .Req_in(Req_in), .Data_in(Data_in),
    .Ack_out(ack2), .Rx_data(data2), .Rx_valid(valid2), .Rx_ready(Rx_ready),
    .Busy(busy2), .Xfer_count(cnt2)
  );

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic reset_dut();
    Req_in   = 1'b0;
    Rx_ready = 1'b0;
    Reset    = 1'b0;
    tick();
    tick();
    Reset     = 1'b1;
    exp_count = 0;
  endtask

`ifndef HANDSHAKE_RESPONDER_EARLY_ACK_EN
  // One complete four-phase transfer as the remote side sees it, with the sink
  // stalling for hold_cycles after the word appears.
  task automatic do_transfer(input logic [7:0] d, input int hold_cycles);
    int n;
    Data_in  = d;
    Req_in   = 1'b1;
    Rx_ready = 1'b0;
    n = 0;
    do begin tick(); n++; end while (Rx_valid !== 1'b1 && n < 20);
    checks++;
    if (n != STG + 1 || Rx_valid !== 1'b1) begin
      errors++;
      $display("FAIL capture_latency: got %0d edges (valid=%b), want %0d", n, Rx_valid, STG + 1);
    end
    exp_count++;
    checks++;
    if (Rx_data !== d || Busy !== 1'b1 || Ack_out !== 1'b0) begin
      errors++;
      $display("FAIL capture_word: data=%h busy=%b ack=%b, want data=%h busy=1 ack=0", Rx_data, Busy, Ack_out, d);
    end
    checks++;
    if (Xfer_count !== exp_count[15:0] || cnt2 !== exp_count[1:0]) begin
      errors++;
      $display("FAIL xfer_count: got %0d / %0d, want %0d / %0d", Xfer_count, cnt2, exp_count[15:0], exp_count[1:0]);
    end
    for (int i = 0; i < hold_cycles; i++) begin
      tick();
      checks++;
      if (Rx_valid !== 1'b1 || Rx_data !== d || Busy !== 1'b1 || Ack_out !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: valid=%b data=%h busy=%b ack=%b, want 1 %h 1 0", i, Rx_valid, Rx_data, Busy, Ack_out, d);
      end
    end
    Rx_ready = 1'b1;
    tick();
    Rx_ready = 1'b0;
    checks++;
    if (Ack_out !== 1'b1 || Rx_valid !== 1'b0 || Busy !== 1'b1) begin
      errors++;
      $display("FAIL consume_ack: ack=%b valid=%b busy=%b, want 1 0 1", Ack_out, Rx_valid, Busy);
    end
    Req_in  = 1'b0;
    Data_in = 8'($urandom);
    n = 0;
    do begin tick(); n++; end while (Ack_out !== 1'b0 && n < 20);
    checks++;
    if (n != STG + 1 || Busy !== 1'b0 || Rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL ack_release: got %0d edges busy=%b valid=%b, want %0d edges busy=0 valid=0", n, Busy, Rx_valid, STG + 1);
    end
  endtask
`endif

  task automatic test_reset();
    Req_in   = 1'b1;
    Data_in  = 8'h5A;
    Rx_ready = 1'b0;
    Reset    = 1'b0;
    repeat (3) tick();
    checks++;
    if (Ack_out !== 1'b0 || Rx_valid !== 1'b0 || Rx_data !== 8'h00 || Xfer_count !== 16'd0 || Busy !== 1'b0 ||
        ack2 !== 1'b0 || valid2 !== 1'b0 || data2 !== 8'h00 || cnt2 !== 2'd0 || busy2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: ack=%b valid=%b data=%h cnt=%0d busy=%b, want all zero", Ack_out, Rx_valid, Rx_data, Xfer_count, Busy);
    end
    Reset     = 1'b1;
    exp_count = 0;
`ifndef HANDSHAKE_RESPONDER_EARLY_ACK_EN
    do_transfer(8'h5A, 0);
`endif
  endtask

`ifndef HANDSHAKE_RESPONDER_EARLY_ACK_EN
  task automatic test_single();
    reset_dut();
    do_transfer(8'hA5, 0);
  endtask

  task automatic test_backpressure();
    reset_dut();
    do_transfer(8'h3C, 20);
  endtask

  task automatic test_wrap();
    logic [1:0] want [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      do_transfer(8'($urandom), 0);
      checks++;
      if (cnt2 !== want[i]) begin
        errors++;
        $display("FAIL counter_wrap[%0d]: got %0d, want %0d", i, cnt2, want[i]);
      end
    end
  endtask

  task automatic test_random();
    reset_dut();
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      do_transfer(8'($urandom), int'($urandom_range(0, 4)));
    end
  endtask

  task automatic test_mid_reset();
    int n;
    reset_dut();
    Data_in = 8'h77;
    Req_in  = 1'b1;
    n = 0;
    do begin tick(); n++; end while (Rx_valid !== 1'b1 && n < 20);
    checks++;
    if (Rx_valid !== 1'b1 || Rx_data !== 8'h77) begin
      errors++;
      $display("FAIL mid_reset_hold: valid=%b data=%h, want 1 77", Rx_valid, Rx_data);
    end
    Reset = 1'b0;
    tick();
    tick();
    checks++;
    if (Ack_out !== 1'b0 || Rx_valid !== 1'b0 || Busy !== 1'b0 || Xfer_count !== 16'd0) begin
      errors++;
      $display("FAIL mid_reset_clear: ack=%b valid=%b busy=%b cnt=%0d, want 0 0 0 0", Ack_out, Rx_valid, Busy, Xfer_count);
    end
    Reset     = 1'b1;
    exp_count = 0;
    do_transfer(8'h77, 1);
  endtask
`else
  task automatic test_early_ack();
    int n;
    reset_dut();
    Data_in = 8'h11;
    Req_in  = 1'b1;
    n = 0;
    do begin tick(); n++; end while (Ack_out !== 1'b1 && n < 20);
    checks++;
    if (n != STG + 1 || Rx_valid !== 1'b1 || Rx_data !== 8'h11) begin
      errors++;
      $display("FAIL early_capture: edges=%0d valid=%b data=%h, want %0d 1 11", n, Rx_valid, Rx_data, STG + 1);
    end
    Req_in = 1'b0;
    n = 0;
    do begin tick(); n++; end while (Ack_out !== 1'b0 && n < 20);
    checks++;
    if (n != STG + 1) begin
      errors++;
      $display("FAIL early_release: got %0d edges, want %0d", n, STG + 1);
    end
    Data_in = 8'h22;
    Req_in  = 1'b1;
    repeat (6) tick();
    checks++;
    if (Ack_out !== 1'b0 || Rx_valid !== 1'b1 || Rx_data !== 8'h11 || Xfer_count !== 16'd1) begin
      errors++;
      $display("FAIL early_stall: ack=%b valid=%b data=%h cnt=%0d, want 0 1 11 1", Ack_out, Rx_valid, Rx_data, Xfer_count);
    end
    Rx_ready = 1'b1;
    tick();
    Rx_ready = 1'b0;
    checks++;
    if (Ack_out !== 1'b1 || Rx_valid !== 1'b1 || Rx_data !== 8'h22 || Xfer_count !== 16'd2) begin
      errors++;
      $display("FAIL early_swap: ack=%b valid=%b data=%h cnt=%0d, want 1 1 22 2", Ack_out, Rx_valid, Rx_data, Xfer_count);
    end
    Req_in = 1'b0;
    repeat (STG + 2) tick();
    Rx_ready = 1'b1;
    tick();
    Rx_ready = 1'b0;
    checks++;
    if (Ack_out !== 1'b0 || Rx_valid !== 1'b0 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL early_drain: ack=%b valid=%b busy=%b, want 0 0 0", Ack_out, Rx_valid, Busy);
    end
  endtask
`endif

  initial begin
    Reset     = 1'b0;
    Req_in    = 1'b0;
    Data_in   = 8'h00;
    Rx_ready  = 1'b0;
    exp_count = 0;
    test_reset();
`ifdef HANDSHAKE_RESPONDER_EARLY_ACK_EN
    test_early_ack();
`else
    test_single();
    test_backpressure();
    test_wrap();
    test_random();
    test_mid_reset();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
